// File: rtl/pgm_snd_pkg.sv
// Shared constants and width helpers for the PGM 68k<->Z80 sound-latch bridge.
package pgm_snd_pkg;

    // Bit positions inside the 68k control-register write data.
    localparam int CTRL_Z80_RST = 0;
    localparam int CTRL_OVF_CLR = 1;

    // m_status is three NUM_CH-wide fields; offset of a field = slot * NUM_CH.
    localparam int ST_NE_SLOT  = 0;
    localparam int ST_RV_SLOT  = 1;
    localparam int ST_OVF_SLOT = 2;

    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/pgm_latch_fifo.sv
// Single-channel 68k->Z80 latch FIFO; an empty pop re-presents the last popped value.
module pgm_latch_fifo
    import pgm_snd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] rd_val_o,
    output logic              nonempty_o,
    output logic              ovf_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] last_q;
    logic              full, empty, pop_ok, push_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign pop_ok  = pop_i & ~empty;
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push_i & (~full | pop_ok);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign rd_val_o   = empty ? last_q : mem_q[rd_ptr_q];
    assign nonempty_o = ~empty;
    assign ovf_o      = push_i & ~push_ok;

endmodule

// File: rtl/pgm_sndlatch_bridge.sv
// Parametrised 68k<->Z80 sound-latch bridge: per-channel FIFOs, reply registers, Z80 INT/reset.
// Optional NMI pulse generator enabled by defining PGM_SNDLATCH_NMI_EN.
module pgm_sndlatch_bridge
    import pgm_snd_pkg::*;
#(
    parameter int                NUM_CH    = 3,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 4,
    parameter logic [NUM_CH-1:0] INT_MASK  = 3'b001,
    parameter int                NMI_PULSE = 16,
    localparam int               CH_W      = ch_w(NUM_CH)
) (
    input  logic                  fixed_20m_clk,
    input  logic                  reset,
    input  logic                  m_sel,
    input  logic                  m_we,
    input  logic [CH_W-1:0]       m_ch,
    input  logic [DATA_W-1:0]     m_din,
    output logic [DATA_W-1:0]     m_dout,
    input  logic                  m_ctrl_we,
    output logic [3*NUM_CH-1:0]   m_status,
    input  logic                  z_sel,
    input  logic                  z_we,
    input  logic [CH_W-1:0]       z_ch,
    input  logic [DATA_W-1:0]     z_din,
    output logic [DATA_W-1:0]     z_dout,
    output logic                  z_int_n,
    output logic                  z_nmi_n,
    output logic                  z80_reset_out
);
    // Both sides are single-cycle strobes (sel qualifies we/ch/data); there is no
    // back-pressure, so every strobe is acted on or dropped in the cycle it appears.

    logic [NUM_CH-1:0]             m_push, m_rd, z_pop, z_wr;
    logic [NUM_CH-1:0]             fifo_ne, fifo_ovf;
    logic [NUM_CH-1:0][DATA_W-1:0] fifo_rd_val;
    logic [NUM_CH-1:0][DATA_W-1:0] reply_q, reply_d;
    logic [NUM_CH-1:0]             rv_q, rv_d, ovf_q, ovf_d;
    logic [DATA_W-1:0]             m_dout_q, m_dout_d, z_dout_q, z_dout_d;
    logic [DATA_W-1:0]             m_rd_val, z_rd_val;
    logic                          z80_rst_q, z80_rst_d, int_n_q, int_n_d;
    logic                          z_act;

    // The Z80 side is inert while it is held in reset.
    assign z_act = z_sel & ~z80_rst_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);
        assign m_push[i] = m_sel & m_we  & (m_ch == IDX);
        assign m_rd[i]   = m_sel & ~m_we & (m_ch == IDX);
        assign z_pop[i]  = z_act & ~z_we & (z_ch == IDX);
        assign z_wr[i]   = z_act & z_we  & (z_ch == IDX);

        pgm_latch_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i      (fixed_20m_clk),
            .reset_i    (reset),
            .push_i     (m_push[i]),
            .pop_i      (z_pop[i]),
            .din_i      (m_din),
            .rd_val_o   (fifo_rd_val[i]),
            .nonempty_o (fifo_ne[i]),
            .ovf_o      (fifo_ovf[i])
        );
    end

    // Out-of-range channel indices fall through to all-ones.
    always_comb begin
        m_rd_val = '1;
        z_rd_val = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_ch == CH_W'(i)) m_rd_val = reply_q[i];
            if (z_ch == CH_W'(i)) z_rd_val = fifo_rd_val[i];
        end
    end

    always_comb begin
        reply_d   = reply_q;
        rv_d      = rv_q;
        ovf_d     = ovf_q;
        m_dout_d  = m_dout_q;
        z_dout_d  = z_dout_q;
        z80_rst_d = z80_rst_q;
        if (m_ctrl_we) begin
            z80_rst_d = m_din[CTRL_Z80_RST];
            if (m_din[CTRL_OVF_CLR]) ovf_d = '0;
        end
        ovf_d = ovf_d | fifo_ovf;
        // Reply write is evaluated after the read clear so a same-cycle set wins.
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_rd[i]) rv_d[i] = 1'b0;
            if (z_wr[i]) begin
                reply_d[i] = z_din;
                rv_d[i]    = 1'b1;
            end
        end
        if (m_sel && !m_we) m_dout_d = m_rd_val;
        if (z_act && !z_we) z_dout_d = z_rd_val;
        int_n_d = ~|(fifo_ne & INT_MASK);
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            reply_q   <= '0;
            rv_q      <= '0;
            ovf_q     <= '0;
            m_dout_q  <= '0;
            z_dout_q  <= '1;
            z80_rst_q <= 1'b1;
            int_n_q   <= 1'b1;
        end else begin
            reply_q   <= reply_d;
            rv_q      <= rv_d;
            ovf_q     <= ovf_d;
            m_dout_q  <= m_dout_d;
            z_dout_q  <= z_dout_d;
            z80_rst_q <= z80_rst_d;
            int_n_q   <= int_n_d;
        end
    end

    assign m_dout        = m_dout_q;
    assign z_dout        = z_dout_q;
    assign z_int_n       = int_n_q;
    assign z80_reset_out = z80_rst_q;

    assign m_status[ST_NE_SLOT*NUM_CH  +: NUM_CH] = fifo_ne;
    assign m_status[ST_RV_SLOT*NUM_CH  +: NUM_CH] = rv_q;
    assign m_status[ST_OVF_SLOT*NUM_CH +: NUM_CH] = ovf_q;

`ifdef PGM_SNDLATCH_NMI_EN
    localparam int NMI_W = $clog2(NMI_PULSE + 1);
    logic [NMI_W-1:0] nmi_cnt_q, nmi_cnt_d;

    // Each accepted channel-0 push (re)loads the full pulse width.
    always_comb begin
        nmi_cnt_d = nmi_cnt_q;
        if (m_push[0] && !fifo_ovf[0] && !z80_rst_q) nmi_cnt_d = NMI_W'(NMI_PULSE);
        else if (nmi_cnt_q != '0)                     nmi_cnt_d = nmi_cnt_q - 1'b1;
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) nmi_cnt_q <= '0;
        else       nmi_cnt_q <= nmi_cnt_d;
    end

    assign z_nmi_n = (nmi_cnt_q == '0);
`else
    assign z_nmi_n = 1'b1;
`endif

endmodule

// File: doc/pgm_sndlatch_bridge.md
Name: pgm_sndlatch_bridge

Overview:
- Parametrised 68k↔Z80 sound-latch bridge; successor to the fixed three-register latch scheme in the PGM top level.
- Provides NUM_CH channels. Each channel has a DEPTH-entry FIFO in the 68k→Z80 direction and a single reply register with a valid flag in the Z80→68k direction.
- Generates the Z80 maskable interrupt and owns the Z80 reset-control register.
- Sits between the 68k C0xxxx decode and the Z80 IORQ decode. Both CPU sides arrive as one-cycle strobes in the fixed_20m_clk domain.

Parameters:
- NUM_CH, 3, number of latch channels (1..8).
- DATA_W, 8, latch data width.
- DEPTH, 4, 68k→Z80 FIFO entries per channel; power of two, ≥2.
- INT_MASK, 3'b001, per-channel enable for Z80 interrupt generation (NUM_CH bits).
- NMI_PULSE, 16, NMI low width in clocks (optional feature only).

Ports:
- fixed_20m_clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- m_sel  in  1  68k access strobe, one cycle per bus access
- m_we  in  1  1 = write, 0 = read
- m_ch  in  CH_W  channel index; CH_W = max(1, $clog2(NUM_CH))
- m_din  in  DATA_W  write data
- m_dout  out  DATA_W  reply-register read data
- m_ctrl_we  in  1  write strobe for the Z80 control register
- m_status  out  3*NUM_CH  {overflow[N-1:0], reply_valid[N-1:0], fifo_nonempty[N-1:0]}
- z_sel  in  1  Z80 access strobe
- z_we  in  1  1 = write reply, 0 = pop FIFO
- z_ch  in  CH_W  channel index
- z_din  in  DATA_W  reply data
- z_dout  out  DATA_W  FIFO pop data
- z_int_n  out  1  Z80 INT, active low, level
- z_nmi_n  out  1  Z80 NMI, active low
- z80_reset_out  out  1  holds the Z80 in reset when 1

Behaviour:
- Reset values:
  - All FIFOs empty; counts 0.
  - reply_valid = 0; overflow = 0.
  - m_dout = 0; z_dout = {DATA_W{1'b1}}.
  - z_int_n = 1; z_nmi_n = 1; z80_reset_out = 1.
  - Reset applied mid-operation discards all queued data on the next edge.
- 68k write (m_sel & m_we):
  - If FIFO[m_ch] is not full, push; count increments the next cycle.
  - If full, discard data and set overflow[m_ch] (sticky).
- 68k read (m_sel & !m_we):
  - m_dout <= reply[m_ch] and reply_valid[m_ch] clears, both on the same edge; 1-cycle latency.
  - m_dout holds its value until the next read.
- Z80 pop (z_sel & !z_we):
  - If FIFO[z_ch] is non-empty, z_dout <= head and the pointer advances; 1-cycle latency.
  - If empty, z_dout <= last popped value of that channel (initially all-ones) and no pointer change.
- Z80 reply write (z_sel & z_we):
  - reply[z_ch] <= z_din; reply_valid set. An unread reply is overwritten silently.
- Overflow clear: m_ctrl_we with m_din[1]=1 clears all overflow bits.
- Z80 reset control:
  - m_ctrl_we: z80_reset_out <= m_din[0].
  - While z80_reset_out=1, Z80-side strobes are ignored; FIFOs are retained.
- Simultaneous events on the same channel, same cycle:
  - Push + pop: both take effect. A pop from an empty FIFO returns the stale value; no bypass.
  - Push to a full FIFO + pop: the pop frees a slot, so the push is accepted and overflow is not set.
  - Z80 reply write + 68k reply read: the 68k gets the old value and reply_valid stays 1 (set wins).
  - If overflow clear and an overflowing push occur in the same cycle, set wins.
- Out-of-range channel (m_ch or z_ch ≥ NUM_CH): writes ignored; reads return all-ones.
- z_int_n: registered; low when OR over channels of (fifo_nonempty & INT_MASK) is 1; 1-cycle lag behind count change.
- Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH+1).

Optional Feature:
- Macro: PGM_SNDLATCH_NMI_EN.
- Defined:
  - A 68k push accepted on channel 0 drives z_nmi_n low for exactly NMI_PULSE cycles, starting the cycle after the push.
  - A new push during an active pulse restarts the counter.
  - No pulse is generated while z80_reset_out=1.
- Undefined: z_nmi_n is constant 1 and no counter is built.

Decomposition:
- Package pgm_snd_pkg: CH_W/count-width functions, status field offsets, control bit positions (CTRL_Z80_RST=0, CTRL_OVF_CLR=1).
- One sub-module, pgm_latch_fifo: single-channel FIFO with push/pop/full/empty/last-value hold. Instantiated NUM_CH times via generate.

Test Plan:
- Reset, then 68k writes 0x11,0x22 to ch0 with z80_reset_out cleared → z_int_n low 1 cycle after first push; pops return 0x11 then 0x22; z_int_n returns high after the second pop.
- 5 writes (0xA0..0xA4) to ch1 with DEPTH=4 → overflow[1]=1; pops return 0xA0..0xA3; 5th pop returns 0xA3 again.
- Ch2 full, push 0x55 and pop in the same cycle → pop yields the oldest entry, 0x55 is queued, overflow[2] stays 0.
- Z80 writes 0x7E to reply ch2 → reply_valid[2]=1; 68k read gives m_dout=0x7E next cycle and reply_valid[2]=0.
- z80_reset_out=1, Z80 pop strobe on a non-empty ch0 → count unchanged, z_dout unchanged; then reset asserted → all status bits 0, z80_reset_out=1.
- With PGM_SNDLATCH_NMI_EN, push on ch0 → z_nmi_n low for exactly 16 cycles; second push at cycle 10 extends low to cycle 26.
